// File: rtl/elevator_request_registry.sv
// ---------------------------------------------------------------------------
// elevator_request_registry
//
// Purpose:
//   Clocked request registry for the elevator controller. It edge-detects the
//   cab and landing buttons and latches each press as a lamp bit. A lamp stays
//   lit until the car serves that floor in the matching direction. The block
//   also publishes above/below/here summaries relative to the car and a
//   registered count of lit lamps. It sits between the button I/O and the
//   car-motion FSM.
//
// Optional feature (compile-time macro CAB_CANCEL_EN):
//   When defined, a second press on a lit cab lamp cancels that lamp. Landing
//   lamps never cancel. When undefined, pressing a lit lamp does nothing.
//
// Parameters:
//   FLOORS  : number of floors (>=2); floor 0 is the bottom
//   FLOOR_W : car_floor width, 2**FLOOR_W >= FLOORS
//   HOLDOFF : cycles after door close during which presses at the
//             last-served floor are ignored (0 disables)
//
// Ports:
//   clk, reset             : clock, synchronous active-high reset
//   buttons_block          : 1 = ignore new presses (clears still act)
//   btn_in[FLOORS]         : cab buttons, bit k = floor k
//   btn_up_out[FLOORS-1]   : up landing buttons, bit k = floor k
//   btn_down_out[FLOORS-1] : down landing buttons, bit k = floor k+1
//   car_floor              : current car floor
//   door_open              : doors open at car_floor
//   serve_dir[1:0]         : directions served at this stop (0 up, 1 down)
//   active_*_levels        : registered lamps (same indexing as buttons)
//   request_above/below/here : any lit floor above/below/at car_floor
//   pending_count          : number of lit lamps (registered)
// ---------------------------------------------------------------------------
module elevator_request_registry #(
  parameter int FLOORS  = 8,
  parameter int FLOOR_W = 3,
  parameter int HOLDOFF = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               buttons_block,
  input  logic [FLOORS-1:0]  btn_in,
  input  logic [FLOORS-2:0]  btn_up_out,
  input  logic [FLOORS-2:0]  btn_down_out,
  input  logic [FLOOR_W-1:0] car_floor,
  input  logic               door_open,
  input  logic [1:0]         serve_dir,
  output logic [FLOORS-1:0]  active_in_levels,
  output logic [FLOORS-2:0]  active_out_up_levels,
  output logic [FLOORS-2:0]  active_out_down_levels,
  output logic               request_above,
  output logic               request_below,
  output logic               request_here,
  output logic [FLOOR_W+1:0] pending_count
);

  // All lamps are kept in one vector: cab [FLOORS-1:0], then up, then down.
  localparam int NB = 3 * FLOORS - 2;
  localparam int HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF);

  logic [NB-1:0]      btn_all;
  logic [NB-1:0]      stage1_q, stage2_q;
  logic [NB-1:0]      lamp_q, lamp_d;
  logic [NB-1:0]      press, accept, set_mask, clr_mask, hold_mask, cancel_mask;
  logic [FLOOR_W+1:0] count_q, count_d;
  logic               door_q;
  logic [HW-1:0]      hold_cnt_q, hold_cnt_d;
  logic [FLOOR_W-1:0] hold_floor_q, hold_floor_d;
  logic [1:0]         hold_dir_q, hold_dir_d;

  logic               floor_valid;
  logic               door_rise, door_fall;
  logic [FLOORS-1:0]  at_car, at_hold;
  logic [FLOORS-1:0]  clr_up_f, clr_dn_f, hold_up_f, hold_dn_f;
  logic [FLOORS-1:0]  lit_up_f, lit_dn_f, lit_f;

  assign btn_all     = {btn_down_out, btn_up_out, btn_in};
  assign press       = stage1_q & ~stage2_q;
  assign floor_valid = (int'(car_floor) < FLOORS);
  assign door_rise   = door_open & ~door_q;
  assign door_fall   = ~door_open & door_q;

  // One-hot floor selects for the serving floor and the holdoff floor.
  // An out-of-range car_floor or captured floor matches nothing.
  always_comb begin
    at_car  = '0;
    at_hold = '0;
    for (int k = 0; k < FLOORS; k++) begin
      at_car[k]  = door_open && floor_valid && (car_floor == FLOOR_W'(k));
      at_hold[k] = (hold_cnt_q != '0) && (hold_floor_q == FLOOR_W'(k));
    end
  end

  // Floor-indexed masks are sliced into the per-category bit positions;
  // the down category drops floor 0 and the up category drops the top floor.
  assign clr_up_f  = at_car & {FLOORS{serve_dir[0]}};
  assign clr_dn_f  = at_car & {FLOORS{serve_dir[1]}};
  assign hold_up_f = at_hold & {FLOORS{hold_dir_q[0]}};
  assign hold_dn_f = at_hold & {FLOORS{hold_dir_q[1]}};

  assign clr_mask  = {clr_dn_f[FLOORS-1:1], clr_up_f[FLOORS-2:0], at_car};
  assign hold_mask = {hold_dn_f[FLOORS-1:1], hold_up_f[FLOORS-2:0], at_hold};

  assign accept   = press & ~hold_mask & {NB{~buttons_block}};
  assign set_mask = accept & ~lamp_q;

`ifdef CAB_CANCEL_EN
  assign cancel_mask = {{(NB-FLOORS){1'b0}}, accept[FLOORS-1:0] & lamp_q[FLOORS-1:0]};
`else
  assign cancel_mask = '0;
`endif

  // Service clear is applied last so it wins over a coincident press.
  assign lamp_d = (lamp_q | set_mask) & ~cancel_mask & ~clr_mask;

  always_comb begin
    count_d = '0;
    for (int k = 0; k < NB; k++) begin
      count_d = count_d + {{(FLOOR_W+1){1'b0}}, lamp_d[k]};
    end
  end

  // Holdoff: a door rise aborts, a door fall arms, otherwise count down.
  // hold_dir tracks serve_dir while the door is open, so after close it
  // holds the directions served at the last stop.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (door_rise) begin
      hold_cnt_d = '0;
    end else if (door_fall) begin
      hold_cnt_d = HOLD_LOAD;
    end else if (hold_cnt_q != '0) begin
      hold_cnt_d = hold_cnt_q - 1'b1;
    end
    hold_floor_d = door_fall ? car_floor : hold_floor_q;
    hold_dir_d   = door_open ? serve_dir : hold_dir_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // Sample stages load ones so a button held through reset is not a press.
      stage1_q     <= '1;
      stage2_q     <= '1;
      lamp_q       <= '0;
      count_q      <= '0;
      door_q       <= 1'b0;
      hold_cnt_q   <= '0;
      hold_floor_q <= '0;
      hold_dir_q   <= '0;
    end else begin
      stage1_q     <= btn_all;
      stage2_q     <= stage1_q;
      lamp_q       <= lamp_d;
      count_q      <= count_d;
      door_q       <= door_open;
      hold_cnt_q   <= hold_cnt_d;
      hold_floor_q <= hold_floor_d;
      hold_dir_q   <= hold_dir_d;
    end
  end

  // Summaries: a floor is lit if any of its existing lamps is lit.
  assign lit_up_f = {1'b0, lamp_q[FLOORS +: FLOORS-1]};
  assign lit_dn_f = {lamp_q[2*FLOORS-1 +: FLOORS-1], 1'b0};
  assign lit_f    = lamp_q[FLOORS-1:0] | lit_up_f | lit_dn_f;

  always_comb begin
    request_above = 1'b0;
    request_below = 1'b0;
    request_here  = 1'b0;
    if (floor_valid) begin
      for (int k = 0; k < FLOORS; k++) begin
        if (FLOOR_W'(k) > car_floor) begin
          request_above = request_above | lit_f[k];
        end else if (FLOOR_W'(k) < car_floor) begin
          request_below = request_below | lit_f[k];
        end else begin
          request_here = request_here | lit_f[k];
        end
      end
    end else begin
      // Car reported beyond the top floor: everything is below it.
      request_below = |lit_f;
    end
  end

  assign active_in_levels       = lamp_q[FLOORS-1:0];
  assign active_out_up_levels   = lamp_q[FLOORS +: FLOORS-1];
  assign active_out_down_levels = lamp_q[2*FLOORS-1 +: FLOORS-1];
  assign pending_count          = count_q;

endmodule
